// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width and ALU operation encodings.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    AluAdd   = 3'b000,
    AluSub   = 3'b001,
    AluNeg   = 3'b010,
    AluPassA = 3'b011,
    AluPassB = 3'b100,
    AluAnd   = 3'b101,
    AluOr    = 3'b110,
    AluXor   = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU; all arithmetic wraps modulo 2^32.
module alu32
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    unique case (alu_op_e'(op))
      AluAdd:   y = a + b;
      AluSub:   y = a - b;
      AluNeg:   y = '0 - a;
      AluPassA: y = a;
      AluPassB: y = b;
      AluAnd:   y = a & b;
      AluOr:    y = a | b;
      AluXor:   y = a ^ b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, condition flags, branch resolution with a squash shadow, EX/MEM register.
// State advances on the falling clock edge.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned SHADOW = 2,
  parameter int unsigned RW     = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] PC,
  input  logic [RW-1:0]   rd,
  input  logic            brz,
  input  logic            brn,
  input  logic            j,
  input  logic            regw,
  input  logic            wai,
  input  logic            memw,
  input  logic            memr,
  input  logic            alusrc,
  input  logic [2:0]      aluop,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_wdata,
  output logic [RW-1:0]   out_rd,
  output logic            out_regw,
  output logic            out_memw,
  output logic            out_memr,
  output logic            out_valid,
  output logic            out_pc_sel,
  output logic [XLEN-1:0] out_target,
  output logic            flag_z,
  output logic            flag_n
);

  localparam int unsigned CW = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);
  localparam logic [CW-1:0] ShadowLd = CW'(SHADOW);

  logic [XLEN-1:0] op_b, alu_y, result;
  logic            live, taken;

  logic [XLEN-1:0] result_d, result_q, wdata_d, wdata_q, target_d, target_q;
  logic [RW-1:0]   rd_d, rd_q;
  logic            regw_d, regw_q, memw_d, memw_q, memr_d, memr_q;
  logic            valid_d, valid_q, pc_sel_d, pc_sel_q;
  logic            fz_d, fz_q, fn_d, fn_q;
  logic [CW-1:0]   sq_d, sq_q;

  alu32 u_alu (
    .a  (rd1),
    .b  (op_b),
    .op (aluop),
    .y  (alu_y)
  );

  always_comb begin
    op_b   = alusrc ? imm : rd2;
    result = wai ? (PC + imm) : alu_y;
    live   = in_valid && (sq_q == '0);
    // Branch conditions see the flags as they stood before this edge.
    taken  = live && (j || (brz && fz_q) || (brn && fn_q));

    result_d = result_q;
    wdata_d  = wdata_q;
    target_d = target_q;
    rd_d     = rd_q;
    regw_d   = regw_q;
    memw_d   = memw_q;
    memr_d   = memr_q;
    valid_d  = valid_q;
    pc_sel_d = pc_sel_q;
    fz_d     = fz_q;
    fn_d     = fn_q;
    sq_d     = sq_q;

    if (!stall) begin
      result_d = result;
      wdata_d  = rd2;
      target_d = rd1;
      rd_d     = rd;
      regw_d   = live && regw;
      memw_d   = live && memw;
      memr_d   = live && memr;
      valid_d  = live;
      pc_sel_d = taken;
      if (in_valid && (sq_q != '0)) begin
        sq_d = sq_q - CW'(1);
      end
      if (taken) begin
        sq_d = ShadowLd;
      end
      if (live && regw && !memr && !wai) begin
        fz_d = (result == '0);
        fn_d = result[XLEN-1];
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      result_q <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      rd_q     <= '0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      memr_q   <= 1'b0;
      valid_q  <= 1'b0;
      pc_sel_q <= 1'b0;
      fz_q     <= 1'b0;
      fn_q     <= 1'b0;
      sq_q     <= '0;
    end else begin
      result_q <= result_d;
      wdata_q  <= wdata_d;
      target_q <= target_d;
      rd_q     <= rd_d;
      regw_q   <= regw_d;
      memw_q   <= memw_d;
      memr_q   <= memr_d;
      valid_q  <= valid_d;
      pc_sel_q <= pc_sel_d;
      fz_q     <= fz_d;
      fn_q     <= fn_d;
      sq_q     <= sq_d;
    end
  end

  assign out_result = result_q;
  assign out_wdata  = wdata_q;
  assign out_target = target_q;
  assign out_rd     = rd_q;
  assign out_regw   = regw_q;
  assign out_memw   = memw_q;
  assign out_memr   = memr_q;
  assign out_valid  = valid_q;
  assign out_pc_sel = pc_sel_q;
  assign flag_z     = fz_q;
  assign flag_n     = fn_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a randomized stream against a
// transaction-level model of the execute stage.
module tb_ex_stage;

  localparam int unsigned SHADOW = 2;
  localparam int unsigned RW     = 6;

  typedef struct {
    logic          v;
    logic [31:0]   imm, rd1, rd2, pc;
    logic [RW-1:0] rd;
    logic          brz, brn, j, regw, wai, memw, memr, alusrc;
    logic [2:0]    op;
  } instr_t;

  logic          clock, reset, stall, in_valid;
  logic [31:0]   imm, rd1, rd2, PC;
  logic [RW-1:0] rd;
  logic          brz, brn, j, regw, wai, memw, memr, alusrc;
  logic [2:0]    aluop;
  logic [31:0]   out_result, out_wdata, out_target;
  logic [RW-1:0] out_rd;
  logic          out_regw, out_memw, out_memr, out_valid, out_pc_sel, flag_z, flag_n;

  int n_chk = 0;
  int n_bad = 0;

  // Model state: flags, instructions left to discard, expected registered outputs.
  logic          m_fz, m_fn;
  int            m_left;
  logic [31:0]   e_result, e_wdata, e_target;
  logic [RW-1:0] e_rd;
  logic          e_regw, e_memw, e_memr, e_valid, e_pcsel;

  ex_stage #(.SHADOW(SHADOW), .RW(RW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid),
    .imm(imm), .rd1(rd1), .rd2(rd2), .PC(PC), .rd(rd),
    .brz(brz), .brn(brn), .j(j), .regw(regw), .wai(wai), .memw(memw), .memr(memr),
    .alusrc(alusrc), .aluop(aluop),
    .out_result(out_result), .out_wdata(out_wdata), .out_rd(out_rd),
    .out_regw(out_regw), .out_memw(out_memw), .out_memr(out_memr), .out_valid(out_valid),
    .out_pc_sel(out_pc_sel), .out_target(out_target), .flag_z(flag_z), .flag_n(flag_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic instr_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic rw);
    instr_t t;
    t.v = 1'b1; t.imm = 32'h0; t.rd1 = a; t.rd2 = b; t.pc = 32'h0; t.rd = RW'(5);
    t.brz = 1'b0; t.brn = 1'b0; t.j = 1'b0; t.regw = rw; t.wai = 1'b0;
    t.memw = 1'b0; t.memr = 1'b0; t.alusrc = 1'b0; t.op = op;
    return t;
  endfunction

  task automatic model_step(input instr_t t, input logic st, input logic rs);
    logic [31:0] a, b, res;
    logic        live, tk;
    if (rs) begin
      m_fz = 0; m_fn = 0; m_left = 0;
      e_result = 0; e_wdata = 0; e_target = 0; e_rd = 0;
      e_regw = 0; e_memw = 0; e_memr = 0; e_valid = 0; e_pcsel = 0;
    end else if (!st) begin
      a = t.rd1;
      b = t.alusrc ? t.imm : t.rd2;
      case (t.op)
        3'd0: res = a + b;
        3'd1: res = a - b;
        3'd2: res = 32'd0 - a;
        3'd3: res = a;
        3'd4: res = b;
        3'd5: res = a & b;
        3'd6: res = a | b;
        default: res = a ^ b;
      endcase
      if (t.wai) res = t.pc + t.imm;
      live = t.v && (m_left == 0);
      tk   = live && (t.j || (t.brz && m_fz) || (t.brn && m_fn));
      if (t.v && m_left > 0) m_left--;
      if (tk) m_left = SHADOW;
      e_result = res; e_wdata = t.rd2; e_target = t.rd1; e_rd = t.rd;
      e_valid = live; e_pcsel = tk;
      e_regw = live && t.regw; e_memw = live && t.memw; e_memr = live && t.memr;
      if (live && t.regw && !t.memr && !t.wai) begin
        m_fz = (res == 32'd0);
        m_fn = res[31];
      end
    end
  endtask

  // Drive one slot, advance the model, and sample just after the falling edge.
  task automatic drive(input instr_t t, input logic st, input logic rs);
    in_valid = t.v; imm = t.imm; rd1 = t.rd1; rd2 = t.rd2; PC = t.pc; rd = t.rd;
    brz = t.brz; brn = t.brn; j = t.j; regw = t.regw; wai = t.wai;
    memw = t.memw; memr = t.memr; alusrc = t.alusrc; aluop = t.op;
    stall = st; reset = rs;
    model_step(t, st, rs);
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    instr_t t;
    t = mk(3'd0, 32'hDEAD, 32'hBEEF, 1'b1);
    t.j = 1'b1;
    drive(t, 1'b1, 1'b1);
    drive(t, 1'b0, 1'b1);
    n_chk++;
    if ({out_result, out_wdata, out_target, out_rd, out_regw, out_memw, out_memr, out_valid,
         out_pc_sel, flag_z, flag_n} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b pcsel=%0b result=%h target=%h fz=%0b fn=%0b, want all 0",
               out_valid, out_pc_sel, out_result, out_target, flag_z, flag_n);
    end
  endtask

  task automatic test_add();
    drive(mk(3'd0, 32'd5, 32'd7, 1'b1), 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1 || out_result !== 32'd12 || out_regw !== 1'b1) begin
      n_bad++;
      $display("FAIL add_result: got valid=%0b regw=%0b result=%0d, want 1 1 12",
               out_valid, out_regw, out_result);
    end
    n_chk++;
    if (flag_z !== 1'b0 || flag_n !== 1'b0) begin
      n_bad++;
      $display("FAIL add_flags: got z=%0b n=%0b, want 0 0", flag_z, flag_n);
    end
  endtask

  task automatic test_sub_brz();
    instr_t t;
    drive(mk(3'd1, 32'd3, 32'd3, 1'b1), 1'b0, 1'b0);
    n_chk++;
    if (out_result !== 32'd0 || flag_z !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_zero: got result=%h z=%0b, want 0 1", out_result, flag_z);
    end
    t = mk(3'd0, 32'h40, 32'h0, 1'b0);
    t.brz = 1'b1;
    drive(t, 1'b0, 1'b0);
    n_chk++;
    if (out_pc_sel !== 1'b1 || out_target !== 32'h40) begin
      n_bad++;
      $display("FAIL brz_taken: got pcsel=%0b target=%h, want 1 00000040", out_pc_sel, out_target);
    end
    for (int k = 0; k < 2; k++) begin
      drive(mk(3'd0, 32'd1, 32'd2, 1'b1), 1'b0, 1'b0);
      n_chk++;
      if (out_valid !== 1'b0 || out_pc_sel !== 1'b0 || out_regw !== 1'b0) begin
        n_bad++;
        $display("FAIL brz_shadow%0d: got valid=%0b pcsel=%0b regw=%0b, want 0 0 0",
                 k, out_valid, out_pc_sel, out_regw);
      end
    end
    drive(mk(3'd0, 32'd1, 32'd2, 1'b1), 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1 || out_result !== 32'd3) begin
      n_bad++;
      $display("FAIL brz_resume: got valid=%0b result=%0d, want 1 3", out_valid, out_result);
    end
  endtask

  task automatic test_neg_brn();
    instr_t t;
    drive(mk(3'd2, 32'd1, 32'd0, 1'b1), 1'b0, 1'b0);
    n_chk++;
    if (out_result !== 32'hFFFF_FFFF || flag_n !== 1'b1 || flag_z !== 1'b0) begin
      n_bad++;
      $display("FAIL neg_result: got result=%h n=%0b z=%0b, want ffffffff 1 0",
               out_result, flag_n, flag_z);
    end
    drive(mk(3'd0, 32'd1, 32'd1, 1'b1), 1'b0, 1'b0);
    t = mk(3'd0, 32'h44, 32'h0, 1'b0);
    t.brn = 1'b1;
    drive(t, 1'b0, 1'b0);
    n_chk++;
    if (out_pc_sel !== 1'b0 || out_valid !== 1'b1 || flag_n !== 1'b0) begin
      n_bad++;
      $display("FAIL brn_not_taken: got pcsel=%0b valid=%0b n=%0b, want 0 1 0",
               out_pc_sel, out_valid, flag_n);
    end
  endtask

  task automatic test_stall();
    instr_t t, jt;
    drive(mk(3'd0, 32'd10, 32'd20, 1'b1), 1'b0, 1'b0);
    jt = mk(3'd0, 32'h80, 32'h0, 1'b0);
    jt.j = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(jt, 1'b1, 1'b0);
      n_chk++;
      if (out_valid !== 1'b1 || out_result !== 32'd30 || out_pc_sel !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold_live%0d: got valid=%0b result=%0d pcsel=%0b, want 1 30 0",
                 k, out_valid, out_result, out_pc_sel);
      end
    end
    drive(jt, 1'b0, 1'b0);
    n_chk++;
    if (out_pc_sel !== 1'b1 || out_target !== 32'h80) begin
      n_bad++;
      $display("FAIL stall_jump: got pcsel=%0b target=%h, want 1 00000080", out_pc_sel, out_target);
    end
    drive(mk(3'd0, 32'd1, 32'd1, 1'b1), 1'b0, 1'b0);
    t = mk(3'd6, 32'hF0, 32'h0F, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(t, 1'b1, 1'b0);
      n_chk++;
      if (out_valid !== 1'b0 || out_pc_sel !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold_shadow%0d: got valid=%0b pcsel=%0b, want 0 0",
                 k, out_valid, out_pc_sel);
      end
    end
    drive(t, 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_no_decrement: got valid=%0b, want 0", out_valid);
    end
    drive(mk(3'd7, 32'hFF, 32'h0F, 1'b1), 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1 || out_result !== 32'hF0) begin
      n_bad++;
      $display("FAIL stall_resume: got valid=%0b result=%h, want 1 000000f0", out_valid, out_result);
    end
  endtask

  task automatic test_reset_squash();
    instr_t jt;
    jt = mk(3'd0, 32'h200, 32'h0, 1'b0);
    jt.j = 1'b1;
    drive(jt, 1'b0, 1'b0);
    drive(mk(3'd0, 32'd1, 32'd1, 1'b1), 1'b0, 1'b0);
    drive(mk(3'd0, 32'd1, 32'd1, 1'b1), 1'b1, 1'b1);
    n_chk++;
    if (out_valid !== 1'b0 || out_pc_sel !== 1'b0 || out_result !== 32'd0 || flag_z !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_squash_clear: got valid=%0b pcsel=%0b result=%h z=%0b, want 0 0 0 0",
               out_valid, out_pc_sel, out_result, flag_z);
    end
    drive(mk(3'd0, 32'd4, 32'd9, 1'b1), 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1 || out_result !== 32'd13) begin
      n_bad++;
      $display("FAIL rst_squash_live: got valid=%0b result=%0d, want 1 13", out_valid, out_result);
    end
  endtask

  task automatic test_wai();
    instr_t t;
    drive(mk(3'd1, 32'd5, 32'd5, 1'b1), 1'b0, 1'b0);
    t = mk(3'd0, 32'h0, 32'h0, 1'b1);
    t.wai = 1'b1; t.pc = 32'h100; t.imm = 32'd4;
    drive(t, 1'b0, 1'b0);
    n_chk++;
    if (out_result !== 32'h104 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wai_result: got result=%h valid=%0b, want 00000104 1", out_result, out_valid);
    end
    n_chk++;
    if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
      n_bad++;
      $display("FAIL wai_flags: got z=%0b n=%0b, want 1 0", flag_z, flag_n);
    end
  endtask

  task automatic test_random();
    instr_t t;
    logic   st, rs;
    for (int i = 0; i < 400; i++) begin
      t.v = ($urandom_range(3) != 0);
      t.imm = $urandom; t.rd1 = $urandom; t.rd2 = $urandom; t.pc = $urandom;
      if ($urandom_range(3) == 0) t.rd2 = t.rd1;
      t.rd = RW'($urandom);
      t.brz = ($urandom_range(3) == 0); t.brn = ($urandom_range(3) == 0);
      t.j = ($urandom_range(7) == 0); t.regw = $urandom_range(1);
      t.wai = ($urandom_range(5) == 0); t.memw = $urandom_range(1);
      t.memr = ($urandom_range(3) == 0); t.alusrc = $urandom_range(1);
      t.op = 3'($urandom);
      st = ($urandom_range(7) == 0);
      rs = ($urandom_range(49) == 0);
      drive(t, st, rs);
      n_chk++;
      if ({out_valid, out_pc_sel, out_regw, out_memw, out_memr} !==
          {e_valid, e_pcsel, e_regw, e_memw, e_memr}) begin
        n_bad++;
        $display("FAIL rnd_ctrl cyc %0d: got v/pc/rw/mw/mr=%b, want %b", i,
                 {out_valid, out_pc_sel, out_regw, out_memw, out_memr},
                 {e_valid, e_pcsel, e_regw, e_memw, e_memr});
      end
      n_chk++;
      if (flag_z !== m_fz || flag_n !== m_fn) begin
        n_bad++;
        $display("FAIL rnd_flags cyc %0d: got z=%0b n=%0b, want %0b %0b", i, flag_z, flag_n,
                 m_fz, m_fn);
      end
      if (e_valid) begin
        n_chk++;
        if (out_result !== e_result || out_wdata !== e_wdata || out_rd !== e_rd) begin
          n_bad++;
          $display("FAIL rnd_data cyc %0d: got res=%h wd=%h rd=%0d, want %h %h %0d", i,
                   out_result, out_wdata, out_rd, e_result, e_wdata, e_rd);
        end
      end
      if (e_pcsel) begin
        n_chk++;
        if (out_target !== e_target) begin
          n_bad++;
          $display("FAIL rnd_target cyc %0d: got %h, want %h", i, out_target, e_target);
        end
      end
    end
  endtask

  initial begin
    stall = 1'b0; reset = 1'b1; in_valid = 1'b0;
    imm = '0; rd1 = '0; rd2 = '0; PC = '0; rd = '0;
    brz = 1'b0; brn = 1'b0; j = 1'b0; regw = 1'b0; wai = 1'b0;
    memw = 1'b0; memr = 1'b0; alusrc = 1'b0; aluop = '0;
    @(negedge clock);
    #1;
    test_reset();
    test_add();
    test_sub_brz();
    test_neg_brn();
    test_stall();
    test_reset_squash();
    test_wai();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter SHADOW, default 2: number of instructions squashed after a taken branch or jump.
REQ-002 SHALL have parameter RW, default 6: register-index width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on the falling edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have port stall  input  1  downstream hold; all state is frozen while high.
REQ-006 SHALL have port in_valid  input  1  an instruction is present from ID/EX.
REQ-007 SHALL have ports imm, rd1, rd2, PC  input  32 each  immediate, two operands, and instruction PC.
REQ-008 SHALL have port rd  input  RW  destination register.
REQ-009 SHALL have ports brz, brn, j, regw, wai, memw, memr, alusrc  input  1 each  decoded controls.
REQ-010 SHALL have port aluop  input  3  ALU operation.
REQ-011 SHALL have ports out_result, out_wdata  output  32 each  EX/MEM result and store data.
REQ-012 SHALL have port out_rd  output  RW  registered destination.
REQ-013 SHALL have ports out_regw, out_memw, out_memr, out_valid  output  1 each  registered controls.
REQ-014 SHALL have ports out_pc_sel  output  1, and out_target  output  32  registered redirect to fetch.
REQ-015 SHALL have ports flag_z, flag_n  output  1 each  condition-flag register.

Function
REQ-016 Operand B SHALL be imm when alusrc=1, otherwise rd2.
REQ-017 aluop SHALL be encoded 000 ADD, 001 SUB (A-B), 010 NEG (0-A), 011 PASSA, 100 PASSB, 101 AND, 110 OR, 111 XOR, all modulo 2^32.
REQ-018 Result SHALL be PC+imm when wai=1, otherwise the ALU output.
REQ-019 A live instruction SHALL be in_valid=1 with squash counter 0; only live instructions have effect.
REQ-020 A live instruction with regw=1, memr=0, wai=0 SHALL update flag_z (result==0) and flag_n (result[31]).
REQ-021 A branch SHALL be taken when live and (j=1, or brz=1 with flag_z=1, or brn=1 with flag_n=1), using the flags as they stood before this edge.
REQ-022 A taken branch SHALL set out_pc_sel=1 and out_target=rd1 for exactly one cycle, and SHALL load the squash counter with SHADOW.
REQ-023 The squash counter SHALL decrement by 1 on each edge with in_valid=1 while nonzero; arriving instructions are discarded during this time.
REQ-024 A taken branch arriving while the counter is nonzero SHALL be ignored.
REQ-025 EX/MEM outputs SHALL register the result, rd2, rd, and the controls one edge after acceptance (latency 1).
REQ-026 out_valid SHALL equal live; non-live slots SHALL force out_regw, out_memw, out_memr and out_pc_sel to 0.
REQ-027 While stall=1, all outputs, the flags and the counter SHALL hold; the input is not consumed.
REQ-028 Branch instructions SHALL write neither flags nor registers unless regw=1.

Reset
REQ-029 reset=1 at an edge SHALL clear all outputs, flags and the counter to 0, overriding stall and any in-flight branch.
REQ-030 The first instruction after reset SHALL be live.

Structure
REQ-031 The aluop encodings and the 32-bit width constant SHALL live in a shared package, cpu_pkg.
REQ-032 A combinational sub-module, alu32 (a, b, op -> y), SHALL implement REQ-017.

Verification
REQ-033 ADD test: rd1=5, rd2=7, aluop=000, regw=1 -> next cycle out_result=12, flag_z=0, flag_n=0.
REQ-034 SUB and branch-on-zero test: SUB 3-3, then brz with rd1=0x40 -> out_pc_sel=1, out_target=0x40; the next two valid instructions give out_valid=0.
REQ-035 Negative-flag test: NEG of 1 gives 0xFFFFFFFF with flag_n=1; then brn with flag_n cleared by an intervening ADD 1+1 -> out_pc_sel=0.
REQ-036 Stall test: stall=1 for 3 cycles mid-stream -> outputs constant, no squash decrement; the stream resumes in order.
REQ-037 Reset test: reset during the squash window -> the counter clears and the next instruction is live.
REQ-038 wai test: wai=1, PC=0x100, imm=4 -> out_result=0x104 with flags unchanged.
